// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and helpers for the BRAM port arbiter.
package bram_port_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int MAX_ADDR = 500;

  // Ceiling log2, floored at 1 so a requester id always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Scan priority slots ptr, ptr+1, ... and take the first active request.
  // Inner loop keeps every bit select on a constant index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (((int'(ptr) + k) % N) == j)) begin
          any       = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port BRAM between NUM_REQ requesters with
// independent round-robin arbitration for the write and read ports.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = bram_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = bram_port_arbiter_pkg::DATA_W,
  parameter int MAX_ADDR = bram_port_arbiter_pkg::MAX_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic [NUM_REQ-1:0]          rsp_err_o,
  output logic                        bram_write_en_o,
  output logic [ADDR_W-1:0]           bram_write_addr_o,
  output logic [DATA_W-1:0]           bram_data_o,
  output logic                        bram_read_en_o,
  output logic [ADDR_W-1:0]           bram_read_addr_o,
  input  logic [DATA_W-1:0]           bram_data_i
);

  localparam int IW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] wr_cand, rd_cand;
  logic [NUM_REQ-1:0] wr_grant, rd_grant;
  logic [IW-1:0]      wr_idx, rd_idx;
  logic               wr_any, rd_any;
  logic [IW-1:0]      wr_ptr, rd_ptr;

  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_oor, rd_oor;

  // One-cycle return pipeline: which requesters were granted, and whether
  // their access was out of range.
  logic [NUM_REQ-1:0] rd_gnt_q, wr_gnt_q;
  logic               rd_err_q, wr_err_q;

  assign wr_cand = req_valid_i & req_we_i;
  assign rd_cand = req_valid_i & ~req_we_i;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .req       (wr_cand),
    .ptr       (wr_ptr),
    .grant     (wr_grant),
    .grant_idx (wr_idx),
    .any       (wr_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .req       (rd_cand),
    .ptr       (rd_ptr),
    .grant     (rd_grant),
    .grant_idx (rd_idx),
    .any       (rd_any)
  );

  // Grants are one-hot within each port, so ready has at most one writer
  // and one reader, and only where the matching valid is set.
  assign req_ready_o = wr_grant | rd_grant;

  // Steer the winners' address and data using the one-hot grants.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (wr_grant[j]) begin
        wr_addr = req_addr_i[j*ADDR_W +: ADDR_W];
        wr_data = req_wdata_i[j*DATA_W +: DATA_W];
      end
      if (rd_grant[j]) rd_addr = req_addr_i[j*ADDR_W +: ADDR_W];
    end
  end

  assign wr_oor = (wr_addr > ADDR_W'(MAX_ADDR));
  assign rd_oor = (rd_addr > ADDR_W'(MAX_ADDR));

  // Round-robin pointers: advance past the winner on a grant, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_any) wr_ptr <= (wr_idx == IW'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1;
      if (rd_any) rd_ptr <= (rd_idx == IW'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
    end
  end

  // RAM control registers; out-of-range accesses are accepted but never
  // reach the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_write_en_o   <= 1'b0;
      bram_write_addr_o <= '0;
      bram_data_o       <= '0;
      bram_read_en_o    <= 1'b0;
      bram_read_addr_o  <= '0;
    end else begin
      bram_write_en_o <= wr_any & ~wr_oor;
      bram_read_en_o  <= rd_any & ~rd_oor;
      if (wr_any && !wr_oor) begin
        bram_write_addr_o <= wr_addr;
        bram_data_o       <= wr_data;
      end
      if (rd_any && !rd_oor) bram_read_addr_o <= rd_addr;
    end
  end

  // Capture grant owners and range errors for the response edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_gnt_q <= '0;
      wr_gnt_q <= '0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      rd_gnt_q <= rd_grant;
      wr_gnt_q <= wr_grant;
      rd_err_q <= rd_any & rd_oor;
      wr_err_q <= wr_any & wr_oor;
    end
  end

  // Responses one edge after accept; data bus holds between responses and
  // reads zero for an out-of-range read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= '0;
      rsp_err_o   <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= rd_gnt_q;
      rsp_err_o   <= (rd_gnt_q & {NUM_REQ{rd_err_q}}) |
                     (wr_gnt_q & {NUM_REQ{wr_err_q}});
      if (|rd_gnt_q) rsp_data_o <= rd_err_q ? '0 : bram_data_i;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a falling-edge BRAM model.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        bram_we;
  logic [8:0]  bram_waddr;
  logic [31:0] bram_wdata;
  logic        bram_re;
  logic [8:0]  bram_raddr;
  logic [31:0] bram_rdata;

  logic [31:0] mem [0:511];

  int total = 0;
  int bad   = 0;

  bram_port_arbiter #(.NUM_REQ(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_we_i          (req_we),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .req_ready_o       (req_ready),
    .rsp_valid_o       (rsp_valid),
    .rsp_data_o        (rsp_data),
    .rsp_err_o         (rsp_err),
    .bram_write_en_o   (bram_we),
    .bram_write_addr_o (bram_waddr),
    .bram_data_o       (bram_wdata),
    .bram_read_en_o    (bram_re),
    .bram_read_addr_o  (bram_raddr),
    .bram_data_i       (bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM sampled on the falling edge.
  always @(negedge clk) begin
    if (bram_re) bram_rdata <= mem[bram_raddr];
    if (bram_we) mem[bram_waddr] <= bram_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [8:0] a, input logic [31:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*9 +: 9]    = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic clear;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [25:0] ctl;
  assign ctl = {req_ready, rsp_valid, rsp_err, bram_we, bram_re, bram_waddr, bram_raddr};

  int cnt0, cnt1;
  logic [8:0] exp_a;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    bram_rdata = '0;
    rst = 1'b1;
    clear();

    // 1: reset and idle
    repeat (3) tick();
    chk("rst_ctl", 64'(ctl), 64'h0);
    chk("rst_data", {rsp_data, bram_wdata}, 64'h0);
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_ctl", 64'(ctl), 64'h0);
    end

    // 3: both requesters write continuously; grants alternate from 0
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, 1'b1, 9'(10 + cnt0), 32'(32'h1000 + cnt0));
      drive(1, 1'b1, 1'b1, 9'(20 + cnt1), 32'(32'h2000 + cnt1));
      #2 chk("rr_wr_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      exp_a = (k % 2 == 0) ? 9'(10 + cnt0) : 9'(20 + cnt1);
      tick();
      chk("rr_wr_en", 64'(bram_we), 64'h1);
      chk("rr_wr_addr", 64'(bram_waddr), 64'(exp_a));
      if (k % 2 == 0) cnt0++; else cnt1++;
    end
    clear();
    tick();
    chk("wr_en_drop", 64'(bram_we), 64'h0);

    // 2: write then read back through another requester
    drive(0, 1'b1, 1'b1, 9'd5, 32'hDEADBEEF);
    #2 chk("t2_wr_ready", 64'(req_ready), 64'h1);
    tick();
    chk("t2_wr_ctl", {31'h0, bram_we, bram_waddr, 23'h0}, {31'h0, 1'b1, 9'd5, 23'h0});
    chk("t2_wr_data", 64'(bram_wdata), 64'hDEADBEEF);
    clear();
    drive(1, 1'b1, 1'b0, 9'd5, 32'h0);
    #2 chk("t2_rd_ready", 64'(req_ready), 64'h2);
    tick();
    chk("t2_rd_ctl", {bram_re, bram_raddr, rsp_valid, bram_we}, {1'b1, 9'd5, 2'b00, 1'b0});
    clear();
    tick();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t2_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("t2_rsp_err", 64'(rsp_err), 64'h0);
    tick();
    chk("t2_rsp_pulse", 64'(rsp_valid), 64'h0);
    chk("t2_data_hold", 64'(rsp_data), 64'hDEADBEEF);

    // 4: same-cycle write and read of one address returns old data
    drive(1, 1'b1, 1'b1, 9'd7, 32'h22);
    #2 chk("t4_pre_ready", 64'(req_ready), 64'h2);
    tick();
    clear();
    drive(0, 1'b1, 1'b1, 9'd7, 32'h11);
    drive(1, 1'b1, 1'b0, 9'd7, 32'h0);
    #2 chk("t4_both_ready", 64'(req_ready), 64'h3);
    tick();
    chk("t4_both_en", {62'h0, bram_we, bram_re}, 64'h3);
    clear();
    tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t4_old_data", 64'(rsp_data), 64'h22);
    drive(0, 1'b1, 1'b0, 9'd7, 32'h0);
    #2 chk("t4_rd2_ready", 64'(req_ready), 64'h1);
    tick();
    clear();
    tick();
    chk("t4_rsp2_valid", 64'(rsp_valid), 64'h1);
    chk("t4_new_data", 64'(rsp_data), 64'h11);

    // 5: out-of-range read then write
    drive(1, 1'b1, 1'b0, 9'd501, 32'h0);
    #2 chk("t5_rd_ready", 64'(req_ready), 64'h2);
    tick();
    chk("t5_no_re", 64'(bram_re), 64'h0);
    clear();
    drive(1, 1'b1, 1'b1, 9'd511, 32'hABC);
    #2 chk("t5_wr_ready", 64'(req_ready), 64'h2);
    tick();
    chk("t5_rd_rsp", {58'h0, rsp_valid, rsp_err, bram_we, 1'b0}, {58'h0, 2'b10, 2'b10, 1'b0, 1'b0});
    chk("t5_rd_zero", 64'(rsp_data), 64'h0);
    clear();
    tick();
    chk("t5_wr_err", {60'h0, rsp_valid, rsp_err}, {60'h0, 2'b00, 2'b10});
    tick();
    chk("t5_err_pulse", 64'(rsp_err), 64'h0);

    // 6: move both pointers to 1, then reset with a read in flight
    drive(0, 1'b1, 1'b1, 9'd9, 32'h99);
    #2;
    tick();
    clear();
    drive(0, 1'b1, 1'b0, 9'd5, 32'h0);
    #2 chk("t6_rd_ready", 64'(req_ready), 64'h1);
    tick();
    chk("t6_re_set", 64'(bram_re), 64'h1);
    clear();
    #2 rst = 1'b1;
    #1 chk("t6_async_drop", {61'h0, bram_we, bram_re, 1'b0}, 64'h0);
    tick();
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_rsp", 64'(rsp_valid), 64'h0);
    end
    drive(0, 1'b1, 1'b1, 9'd12, 32'h12);
    drive(1, 1'b1, 1'b1, 9'd13, 32'h13);
    #2 chk("t6_wr_ptr", 64'(req_ready), 64'h1);
    tick();
    clear();
    drive(0, 1'b1, 1'b0, 9'd12, 32'h0);
    drive(1, 1'b1, 1'b0, 9'd13, 32'h0);
    #2 chk("t6_rd_ptr", 64'(req_ready), 64'h1);
    tick();
    clear();
    tick();
    chk("t6_rsp", 64'(rsp_valid), 64'h1);
    chk("t6_rsp_data", 64'(rsp_data), 64'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one simple dual-port block RAM between NUM_REQ requesters: 32-bit words, 9-bit address, depth 501, independent write and read ports, RAM samples on the falling clock edge.
- Runs two independent round-robin arbiters, one for the RAM write port and one for the read port, so one write and one read can be issued in the same cycle.
- Registers all RAM control signals and returns read data to the originating requester with a fixed latency.

Parameters:
- NUM_REQ, 2, number of requesters; supported range 2..4.
- ADDR_W, 9, RAM address width.
- DATA_W, 32, RAM data width.
- MAX_ADDR, 500, highest valid RAM address.

Ports:
- clk  in  1  clock; all logic in this block acts on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_we_i  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester address, packed.
- req_wdata_i  in  NUM_REQ*DATA_W  per-requester write data, packed.
- req_ready_o  out  NUM_REQ  request accepted this cycle.
- rsp_valid_o  out  NUM_REQ  one-cycle read-data-valid pulse, one bit per requester.
- rsp_data_o  out  DATA_W  read data, shared bus, qualified by rsp_valid_o.
- rsp_err_o  out  NUM_REQ  one-cycle pulse flagging an out-of-range access.
- bram_write_en_o  out  1  RAM write enable, registered.
- bram_write_addr_o  out  ADDR_W  RAM write address, registered.
- bram_data_o  out  DATA_W  RAM write data, registered.
- bram_read_en_o  out  1  RAM read enable, registered.
- bram_read_addr_o  out  ADDR_W  RAM read address, registered.
- bram_data_i  in  DATA_W  RAM read data output.

Behaviour:
- Reset values:
  - all outputs 0;
  - both round-robin pointers select requester 0 as highest priority;
  - read-return pipeline cleared.
- Write arbiter:
  - candidates are requesters with req_valid_i & req_we_i;
  - combinational round-robin pick starting at wr_ptr;
  - req_ready_o of the winner goes high in the same cycle.
- Read arbiter:
  - same scheme over req_valid_i & ~req_we_i, using rd_ptr.
- req_ready_o:
  - high for at most one writer and one reader per cycle;
  - never high without the matching req_valid_i.
- Pointer update:
  - on a grant, that arbiter's pointer becomes winner+1 modulo NUM_REQ;
  - with no grant, the pointer holds.
- Handshake:
  - a requester holds valid, we, addr and wdata stable until ready is seen;
  - the transfer occurs at the rising edge where valid & ready are both high.
- Write path:
  - at the accept edge E0, bram_write_en_o=1 and the address/data registers are loaded;
  - the RAM commits on the falling edge inside cycle E0..E1;
  - bram_write_en_o returns to 0 at E1 unless a new write is granted;
  - back-to-back grants give one write per cycle.
- Read path:
  - at E0, bram_read_en_o=1, bram_read_addr_o loads, and the requester id is stored in a pipeline register;
  - at E1, rsp_data_o <= bram_data_i and the matching rsp_valid_o bit pulses for one cycle;
  - fixed latency: 1 cycle from accept edge to response edge;
  - one read per cycle is sustainable.
- Out-of-range address (addr > MAX_ADDR):
  - the request is still accepted;
  - no RAM enable is raised;
  - at E1 the matching rsp_err_o bit pulses;
  - a read also pulses rsp_valid_o with rsp_data_o = 0.
- Simultaneous write and read to the same address in the same cycle: the read returns the pre-write (old) data.
- A write-err and a read-err pulse may coincide on different requesters.
- Between responses, rsp_data_o holds its last value.
- Reset asserted mid-operation:
  - RAM enables drop immediately (asynchronous);
  - in-flight read responses are discarded, with no rsp_valid_o pulse after reset release;
  - RAM contents are not the block's responsibility.

Decomposition:
- Shared package holds:
  - RAM geometry constants: DATA_W=32, ADDR_W=9, MAX_ADDR=500;
  - function clog2 for the requester-id width.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant, grant_idx, any):
  - combinational;
  - instantiated twice, once for writes and once for reads;
  - pointer registers live in the parent.

Test Plan:
1. Reset, then idle -> all outputs 0; no ready, rsp or enable for 10 cycles.
2. Requester 0 writes 0xDEADBEEF to addr 5; requester 1 reads addr 5 one cycle later -> rsp_valid_o=2'b10 on the next edge after acceptance, with rsp_data_o=0xDEADBEEF.
3. Both requesters hold continuous writes for 6 cycles -> grants alternate 0,1,0,1,0,1; bram_write_en_o high every cycle.
4. Same cycle: requester 0 writes 0x11 to addr 7, requester 1 reads addr 7 (old value 0x22) -> both ready in the same cycle; the read returns 0x22; a follow-up read returns 0x11.
5. Requester 1 reads addr 501, then writes addr 511 -> no RAM enable for either; rsp_err_o[1] pulses for each; the read returns rsp_valid_o[1]=1 with data 0.
6. Read accepted, then rst pulsed before the response edge -> no rsp_valid_o after release; both pointers back to requester 0.
